// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// controller FSM encodings and scoreboard geometry / entry field widths.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } hz_state_e;

  // Scoreboard geometry: one entry per downstream stage.
  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;

  // Scoreboard entry fields: 1-bit valid plus a destination
  // register specifier of SB_DEST_W bits (default width).
  localparam int SB_VALID_W = 1;
  localparam int SB_DEST_W  = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB {valid,dest} shift register with
// RAW match against the ID sources. Ports: clk, rst, hold, ld_*, id_*, hazard, empty.
module hazard_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = SB_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_dest,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  output logic              hazard,
  output logic              empty
);

  logic [SB_DEPTH-1:0][SB_VALID_W-1:0] vld_q, vld_d;
  logic [SB_DEPTH-1:0][REG_AW-1:0]     dst_q, dst_d;

  always_comb begin
    vld_d = vld_q;
    dst_d = dst_q;
    if (!hold) begin
      vld_d = {vld_q[SB_MEM], vld_q[SB_EX], ld_valid};
      dst_d = {dst_q[SB_MEM], dst_q[SB_EX], ld_dest};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dst_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
    end
  end

  // WB is excluded: the RF writes before it is read.
  logic ex_rs, mem_rs, ex_rt, mem_rt;

  always_comb begin
    ex_rs  = vld_q[SB_EX][0]  && (dst_q[SB_EX]  == id_rs);
    mem_rs = vld_q[SB_MEM][0] && (dst_q[SB_MEM] == id_rs);
    ex_rt  = vld_q[SB_EX][0]  && (dst_q[SB_EX]  == id_rt);
    mem_rt = vld_q[SB_MEM][0] && (dst_q[SB_MEM] == id_rt);
    hazard = id_valid &&
             ((id_use_rs && (ex_rs || mem_rs)) ||
              (id_use_rt && (ex_rt || mem_rt)));
    empty  = ~|vld_q;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW stall/bubble generation, memory freeze, HALT drain
// FSM and saturating hazard-stall counter. Outputs: stall_if, bubble_id, freeze, halted, stall_cnt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_en,
  input  logic [REG_AW-1:0] id_wr_reg,
  input  logic              id_halt,
  input  logic              mem_stall,
  output logic              stall_if,
  output logic              bubble_id,
  output logic              freeze,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard, sb_empty, ld_valid, run;

  assign run = (state_q == ST_RUN);

  // HALT is loaded as a non-writing entry.
  assign ld_valid = id_valid && id_reg_en && !id_halt && !hazard && run;

  hazard_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .hold      (mem_stall),
    .ld_valid  (ld_valid),
    .ld_dest   (id_wr_reg),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .hazard    (hazard),
    .empty     (sb_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_stall) begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          end else if (id_valid && id_halt) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN:  if (sb_empty) state_d = ST_HALTED;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Freeze wins: everything holds, so no bubble is inserted.
  always_comb begin
    freeze    = mem_stall;
    stall_if  = mem_stall || !run || hazard;
    bubble_id = !mem_stall && (!run || hazard);
    halted    = (state_q == ST_HALTED);
    stall_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl.
// Inputs change 1 time unit after posedge; outputs are compared at negedge.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_en, id_halt;
  logic [2:0] id_rs, id_rt, id_wr_reg;
  logic       mem_stall;
  logic       stall_if, bubble_id, freeze, halted;
  logic [7:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_reg_en (id_reg_en),
    .id_wr_reg (id_wr_reg),
    .id_halt   (id_halt),
    .mem_stall (mem_stall),
    .stall_if  (stall_if),
    .bubble_id (bubble_id),
    .freeze    (freeze),
    .halted    (halted),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic       v;
    logic [2:0] rs, rt;
    logic       urs, urt, ren;
    logic [2:0] wr;
    logic       hlt, ms;
    logic       e_stall, e_bub, e_frz;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(
    input logic v, input logic [2:0] rs, input logic [2:0] rt,
    input logic urs, input logic urt, input logic ren,
    input logic [2:0] wr, input logic hlt, input logic ms,
    input logic es, input logic eb, input logic ef, input logic [7:0] ec);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt;
    t.ren = ren; t.wr = wr; t.hlt = hlt; t.ms = ms;
    t.e_stall = es; t.e_bub = eb; t.e_frz = ef; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [2:0] rs,
                     input logic [2:0] rt, input logic urs,
                     input logic urt, input logic ren,
                     input logic [2:0] wr, input logic hlt,
                     input logic ms);
    id_valid = v; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt;
    id_reg_en = ren; id_wr_reg = wr;
    id_halt = hlt; mem_stall = ms;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    // v rs rt urs urt ren wr hlt ms | stall bub frz cnt
    tbl[0]  = mk(1,0,0,0,0,1,3,0,0, 0,0,0,0);
    tbl[1]  = mk(1,3,0,1,0,1,4,0,0, 1,1,0,0);
    tbl[2]  = mk(1,3,0,1,0,1,4,0,0, 1,1,0,1);
    tbl[3]  = mk(1,3,0,1,0,1,4,0,0, 0,0,0,2);
    tbl[4]  = mk(1,0,0,0,0,1,3,0,0, 0,0,0,2);
    tbl[5]  = mk(1,1,2,1,1,1,6,0,0, 0,0,0,2);
    tbl[6]  = mk(1,0,0,1,0,1,7,0,0, 0,0,0,2);
    tbl[7]  = mk(1,0,3,0,1,0,0,0,0, 0,0,0,2);
    tbl[8]  = mk(1,7,6,0,0,0,0,0,0, 0,0,0,2);
    tbl[9]  = mk(1,0,0,0,0,1,2,0,0, 0,0,0,2);
    tbl[10] = mk(1,2,0,1,0,1,4,0,1, 1,0,1,2);
    tbl[11] = mk(1,2,0,1,0,1,4,0,1, 1,0,1,2);
    tbl[12] = mk(1,2,0,1,0,1,4,0,1, 1,0,1,2);
    tbl[13] = mk(1,2,0,1,0,1,4,0,1, 1,0,1,2);
    tbl[14] = mk(1,2,0,1,0,1,4,0,0, 1,1,0,2);
    tbl[15] = mk(1,2,0,1,0,1,4,0,0, 1,1,0,3);
    tbl[16] = mk(1,2,0,1,0,0,0,0,0, 0,0,0,4);
    tbl[17] = mk(1,0,0,0,0,1,5,0,0, 0,0,0,4);
    tbl[18] = mk(0,5,5,1,1,1,1,0,0, 0,0,0,4);
    tbl[19] = mk(1,0,5,0,1,0,0,0,0, 1,1,0,4);
    tbl[20] = mk(1,0,5,0,1,0,0,0,0, 0,0,0,5);
    tbl[21] = mk(1,0,0,0,0,1,0,0,0, 0,0,0,5);
    tbl[22] = mk(1,0,0,1,0,0,0,0,0, 1,1,0,5);
    tbl[23] = mk(1,0,0,1,0,0,0,0,0, 1,1,0,6);
    tbl[24] = mk(1,0,0,1,0,0,0,0,0, 0,0,0,7);

    // Reset values
    idle();
    rst = 1'b1;
    #2;
    chk("rst_stall_if", stall_if, 0);
    chk("rst_bubble", bubble_id, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_freeze0", freeze, 0);
    mem_stall = 1'b1;
    #1;
    chk("rst_freeze1", freeze, 1);
    mem_stall = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Table
    for (int i = 0; i < 25; i++) begin
      drv(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
          tbl[i].ren, tbl[i].wr, tbl[i].hlt, tbl[i].ms);
      @(negedge clk);
      chk($sformatf("v%0d_stall_if", i), stall_if, tbl[i].e_stall);
      chk($sformatf("v%0d_bubble", i), bubble_id, tbl[i].e_bub);
      chk($sformatf("v%0d_freeze", i), freeze, tbl[i].e_frz);
      chk($sformatf("v%0d_cnt", i), stall_cnt, tbl[i].e_cnt);
      chk($sformatf("v%0d_halted", i), halted, 0);
      tick();
    end

    // HALT behind writer to r5: 3 drain cycles, then sticky halted
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("halt_accept_stall", stall_if, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_stall", i), stall_if, 1);
      chk($sformatf("drain%0d_bubble", i), bubble_id, 1);
      chk($sformatf("drain%0d_halted", i), halted, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("halted%0d", i), halted, 1);
      chk($sformatf("halted%0d_stall", i), stall_if, 1);
      tick();
    end
    mem_stall = 1'b1;
    @(negedge clk);
    chk("halted_frz_freeze", freeze, 1);
    chk("halted_frz_bubble", bubble_id, 0);
    chk("halted_frz_halted", halted, 1);
    tick();

    // HALT with pending hazard on r1
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drv(1, 1, 0, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("hh%0d_stall", i), stall_if, 1);
      chk($sformatf("hh%0d_bubble", i), bubble_id, 1);
      tick();
    end
    @(negedge clk);
    chk("hh_accept_stall", stall_if, 0);
    chk("hh_accept_cnt", stall_cnt, 2);
    tick();
    @(negedge clk);
    chk("hh_drain_halted", halted, 0);
    chk("hh_drain_stall", stall_if, 1);
    tick();
    @(negedge clk);
    chk("hh_halted", halted, 1);
    tick();

    // Reset asserted mid-DRAIN
    do_reset();
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0);
    tick();
    drv(1, 3, 0, 1, 0, 0, 0, 0, 0);
    repeat (3) tick();
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    @(negedge clk);
    chk("rd_drain_stall", stall_if, 1);
    chk("rd_drain_cnt", stall_cnt, 2);
    rst = 1'b1;
    #1;
    chk("rd_rst_halted", halted, 0);
    chk("rd_rst_stall", stall_if, 0);
    chk("rd_rst_bubble", bubble_id, 0);
    chk("rd_rst_cnt", stall_cnt, 0);
    idle();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rd_after_stall", stall_if, 0);
    tick();

    // 300 hazard cycles: counter saturates at 255
    do_reset();
    for (int i = 0; i < 150; i++) begin
      drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
      @(negedge clk);
      if (i == 100) chk("sat_cnt200", stall_cnt, 200);
      tick();
      drv(1, 1, 0, 1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("sat%0d_stall", i), stall_if, 1);
      repeat (3) tick();
    end
    idle();
    @(negedge clk);
    chk("sat_cnt255", stall_cnt, 255);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 3, meaning register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 8, meaning stall-counter width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port id_valid  in  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rt  in  REG_AW each  source registers (instr[10:8], instr[7:5]).
REQ-007 SHALL have ports id_use_rs, id_use_rt  in  1 each  source actually read.
REQ-008 SHALL have ports id_reg_en  in  1 and id_wr_reg  in  REG_AW  ID instruction writes the RF, and to which register.
REQ-009 SHALL have port id_halt  in  1  ID instruction is HALT.
REQ-010 SHALL have port mem_stall  in  1  cache/memory busy; whole pipeline must freeze.
REQ-011 SHALL have port stall_if  out  1  hold PC and IF/ID register.
REQ-012 SHALL have port bubble_id  out  1  load NOP (reg_en=0, mem_en=0) into ID/EX.
REQ-013 SHALL have port freeze  out  1  hold every pipeline register (copy of mem_stall).
REQ-014 SHALL have port halted  out  1  pipeline drained after HALT; sticky.
REQ-015 SHALL have port stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-016 SHALL keep a 3-entry scoreboard shift register {valid, dest} for EX, MEM, WB stages.
REQ-017 SHALL, per non-frozen cycle, shift EX->MEM->WB and load EX with {id_valid & id_reg_en & ~hazard & state==RUN, id_wr_reg}; bubble loads valid=0.
REQ-018 SHALL assert hazard (combinational) when id_valid and a used source equals dest of a valid EX or MEM entry; WB entry never causes hazard (RF write-before-read).
REQ-019 SHALL ignore register 0 comparisons only if REG_AW dest is 0 and reg_en=0; no other register is special.
REQ-020 SHALL drive stall_if=1 and bubble_id=1 while hazard and not freeze; zero added latency (same cycle).
REQ-021 SHALL, when mem_stall=1, drive freeze=1, stall_if=1, bubble_id=0, and hold scoreboard, FSM and stall_cnt unchanged; freeze has priority over hazard and halt.
REQ-022 SHALL implement FSM RUN, DRAIN, HALTED.
REQ-023 RUN->DRAIN when id_valid & id_halt & ~hazard & ~freeze; HALT itself enters EX as non-writing.
REQ-024 DRAIN: stall_if=1, bubble_id=1; DRAIN->HALTED when scoreboard all invalid and ~freeze.
REQ-025 HALTED: stall_if=1, bubble_id=1, halted=1; no exit except reset.
REQ-026 SHALL increment stall_cnt by 1 each non-frozen RUN cycle with hazard=1, saturating at 2^CNT_W-1.
REQ-027 halt with pending hazard: hazard resolved first, HALT accepted the cycle hazard clears.

Reset
REQ-028 On rst=1 SHALL immediately clear scoreboard valids, dests to 0, FSM to RUN, stall_cnt to 0.
REQ-029 Reset values: stall_if=0, bubble_id=0, halted=0, freeze follows mem_stall.
REQ-030 Reset asserted mid-DRAIN or in HALTED SHALL return to RUN with empty scoreboard on next cycle.

Structure
REQ-031 FSM state encodings and scoreboard-entry field widths SHALL live in the shared pipeline package.
REQ-032 Scoreboard SHALL be one sub-module, hazard_scoreboard (shift, hold, match logic); FSM and counter stay in top.

Verification
REQ-033 ADD r3 issued, next cycle ADD reads r3 -> stall_if=bubble_id=1 for 2 cycles, stall_cnt=2, then proceeds.
REQ-034 Writer to r3, two independent instrs, then reader of r3 -> no stall (WB match only).
REQ-035 Hazard on r2 with mem_stall=1 for 4 cycles -> freeze=1, bubble_id=0, stall_cnt unchanged during freeze.
REQ-036 HALT behind writer to r5 -> DRAIN 3 cycles, halted=1 at 4th cycle and stays 1 for 20 cycles.
REQ-037 rst pulsed in DRAIN -> halted=0, stall_if=0, stall_cnt=0 next cycle; 300 back-to-back hazards -> stall_cnt saturates at 255.
